// File: rtl/hmmm_divider_if.sv
// Operand/result bundle between the core datapath and the HMMM divider.
// Handshake: start is sampled only while busy=0; busy rises the cycle after launch, and done pulses for one cycle as busy falls.
interface hmmm_divider_if;
    logic        start;
    logic        isMod;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        divZero;

    modport master (
        output start, isMod, dividend, divisor,
        input  busy, done, result, divZero
    );

    modport slave (
        input  start, isMod, dividend, divisor,
        output busy, done, result, divZero
    );
endinterface

// File: rtl/hmmm_divider.sv
// Multi-cycle signed 16-bit divider for HMMM div/mod: restoring division on magnitudes,
// then floor correction so the remainder takes the sign of the divisor.
module hmmm_divider (
    input  logic           clk,
    input  logic           reset,
    hmmm_divider_if.slave  bus,
    output logic [1:0]     dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        mod_op;
    logic        neg_dvd;
    logic        neg_dvs;
    logic        zero_dvs;
    logic [15:0] dvs_mag;
    logic [15:0] quo;
    logic [16:0] rem;
    logic [3:0]  cnt;
    logic        done_q;
    logic        div_zero_q;
    logic [15:0] result_q;

    logic [17:0] shifted;
    logic [17:0] trial;
    logic        signs_differ;
    logic [15:0] dvs_signed;
    logic [15:0] q_signed;
    logic [15:0] r_signed;
    logic [15:0] q_fix;
    logic [15:0] r_fix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (cnt == 4'd15) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shifted      = {rem, quo[15]};
        trial        = shifted - {2'b00, dvs_mag};
        signs_differ = neg_dvd ^ neg_dvs;
        dvs_signed   = neg_dvs ? (16'd0 - dvs_mag) : dvs_mag;
        q_signed     = signs_differ ? (16'd0 - quo) : quo;
        r_signed     = neg_dvd ? (16'd0 - rem[15:0]) : rem[15:0];
        q_fix        = q_signed;
        r_fix        = r_signed;
        // Truncated result rounds toward zero; step down once to reach floor.
        if (signs_differ && (r_signed != 16'd0)) begin
            q_fix = q_signed - 16'd1;
            r_fix = r_signed + dvs_signed;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mod_op     <= 1'b0;
            neg_dvd    <= 1'b0;
            neg_dvs    <= 1'b0;
            zero_dvs   <= 1'b0;
            dvs_mag    <= 16'd0;
            quo        <= 16'd0;
            rem        <= 17'd0;
            cnt        <= 4'd0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mod_op   <= bus.isMod;
                        neg_dvd  <= bus.dividend[15];
                        neg_dvs  <= bus.divisor[15];
                        zero_dvs <= (bus.divisor == 16'd0);
                        quo      <= bus.dividend[15] ? (16'd0 - bus.dividend) : bus.dividend;
                        dvs_mag  <= bus.divisor[15] ? (16'd0 - bus.divisor) : bus.divisor;
                        rem      <= 17'd0;
                        cnt      <= 4'd0;
                    end
                end
                CALC: begin
                    if (!trial[17]) begin
                        rem <= trial[16:0];
                        quo <= {quo[14:0], 1'b1};
                    end else begin
                        rem <= shifted[16:0];
                        quo <= {quo[14:0], 1'b0};
                    end
                    cnt <= cnt + 4'd1;
                end
                FIX: begin
                    done_q     <= 1'b1;
                    div_zero_q <= zero_dvs;
                    result_q   <= zero_dvs ? 16'd0 : (mod_op ? r_fix : q_fix);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.divZero = div_zero_q;
    assign dbg_state   = state;
endmodule

// File: doc/hmmm_divider.md
# hmmm_divider

Multi-cycle signed 16-bit divider serving the HMMM `div` and `mod` instructions. It sits beside the ALU and multiplier, directly upstream of the core's result mux. It takes register operands from the datapath and returns one 16-bit result. While it works it raises `busy`, and the control unit uses `busy` to stall the PC. Semantics match the HMMM reference simulator: floor division, with the remainder taking the sign of the divisor.

## Interface
- No parameters; width fixed at 16.
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  launch operation; sampled only in IDLE
- `isMod`  in  1  0 = quotient (`div`), 1 = remainder (`mod`); captured with `start`
- `dividend`  in  16  signed two's complement, captured with `start`
- `divisor`  in  16  signed two's complement, captured with `start`
- `busy`  out  1  high while an operation is in flight; feeds the core's `divBusy`
- `done`  out  1  one-cycle pulse when `result` becomes valid
- `result`  out  16  selected quotient or remainder; feeds the core's `divOut`; held until the next completion
- `divZero`  out  1  sticky with `result`: last completed op had divisor 0

## Operation
- States: IDLE, CALC, FIX.
- **IDLE, `start`=1:**
  - Capture `isMod` and the operand signs.
  - Load `|dividend|` and `|divisor|` as 16-bit unsigned values; `|-32768|` = 0x8000 is exact in unsigned.
  - Clear the partial remainder (17-bit) and the 4-bit iteration count.
  - Go to CALC.
- **IDLE, `start`=0:** stay in IDLE.
- **CALC:** restoring division, one quotient bit per cycle, MSB first.
  - Shift {rem, quo} left by 1.
  - Trial subtract `|divisor|`.
  - If the trial result is non-negative, keep it and set the quotient LSB.
  - After 16 iterations go to FIX.
- **FIX:** sign and floor correction, then register `result`.
  - q = quo negated if the operand signs differ.
  - r = rem negated if the dividend is negative.
  - If r ≠ 0 and the signs differ: q = q − 1, r = r + divisor.
  - Arithmetic is 16-bit modulo 2^16. −32768 div −1 therefore yields 0x8000, and its mod yields 0.
  - `result` = `isMod` ? r : q.
  - Go to IDLE.
- **Divisor = 0:** run the full sequence so latency is uniform. `result` = 0x0000 and `divZero` = 1; otherwise `divZero` = 0.
- **`start` while `busy`:** ignored; captured operands are unaffected.
- **Operand changes after the `start` edge:** no effect on the running operation.

## Timing
- **Reset values (asynchronous):** state IDLE; `busy`=0, `done`=0, `result`=0x0000, `divZero`=0; internal registers cleared.
- **Launch:** `start` sampled high at edge E0 (IDLE). `busy`=1 from after E0.
- **Compute:** CALC occupies E1..E16. FIX occurs at E17.
- **Completion:** after E17, `busy`=0, `done`=1, and `result`/`divZero` are valid. `done` drops after E18.
- **Latency:** 17 cycles from the `start` edge to `done`. Throughput is one operation per 18 cycles at best.
- **Back-to-back:** a new `start` may be sampled at E18, coincident with the `done` cycle.
- **Reset mid-operation:** immediate return to IDLE with all outputs at reset values. No partial result is ever presented.
- **`busy` vs. `done`:** never both high in the same cycle.

## Test plan
- 100 div 7 -> `done` exactly 17 cycles after `start`, `result`=0x000E. Then 100 mod 7 -> 0x0002.
- Signed/floor cases:
  - −7 div 2 -> 0xFFFC
  - −7 mod 2 -> 0x0001
  - 7 div −2 -> 0xFFFC
  - 7 mod −2 -> 0xFFFF
  - −8 mod −3 -> 0xFFFE
- Overflow: −32768 div −1 -> 0x8000, and −32768 mod −1 -> 0x0000. Also −32768 div 1 -> 0x8000.
- 1234 div 0 -> after 17 cycles `result`=0x0000, `divZero`=1. A following 9 div 3 -> 0x0003 with `divZero`=0.
- Launch 50 div 5, then pulse `start` with 9 div 2 at cycle 5 -> ignored; `result`=0x000A and `busy` stays continuously high.
- Assert `reset` at cycle 8 of 30000 div 3 -> all outputs at reset values, no `done`. After release, 30000 div 3 -> 0x2710.
